// File: rtl/pipeline_interlock_ctrl.sv
// EX-stage operand bypass select plus hold/bubble/flush sequencing for the pipeline registers.
// Zero-cycle latency (outputs combinational from state + inputs); dmem stalls freeze the whole pipe.
module pipeline_interlock_ctrl #(
   parameter int RW        = 4,
   parameter int FLUSH_CYC = 1,
   parameter int MAX_WAIT  = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [RW-1:0] id_ex_rs_a,
   input  logic [RW-1:0] id_ex_rs_b,
   input  logic          id_ex_use_a,
   input  logic          id_ex_use_b,
   input  logic          ex_mem_regwrite,
   input  logic [RW-1:0] ex_mem_rd,
   input  logic          ex_mem_is_load,
   input  logic          mem_wb_regwrite,
   input  logic [RW-1:0] mem_wb_rd,
   input  logic          dmem_ready,
   input  logic          branch_taken,
   output logic [1:0]    forward_a,
   output logic [1:0]    forward_b,
   output logic          hold_front,
   output logic          hold_back,
   output logic          bubble_ex,
   output logic          flush_front,
   output logic          mem_timeout
);

   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
   localparam logic [1:0]    FLUSH_INIT = 2'(FLUSH_CYC);
   localparam logic [1:0]    FLUSH_RUN  = 2'(FLUSH_CYC - 1);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_FLUSH
   } state_t;

   state_t          state_q, state_d;
   logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [1:0]      flush_cnt_q, flush_cnt_d;
   logic            branch_pend_q, branch_pend_d;
   logic            mem_timeout_q, mem_timeout_d;

   logic [1:0]      fwd_a, fwd_b;
   logic            load_use;
   logic            waiting;
   logic            exit_flush;
   logic [WW-1:0]   wait_inc;
   logic            hold_front_c, hold_back_c, bubble_c, flush_c;

   always_comb begin
      fwd_a = 2'b00;
      if (ex_mem_regwrite && !ex_mem_is_load && id_ex_use_a && (ex_mem_rd == id_ex_rs_a))
         fwd_a = 2'b10;
      else if (mem_wb_regwrite && id_ex_use_a && (mem_wb_rd == id_ex_rs_a))
         fwd_a = 2'b01;

      fwd_b = 2'b00;
      if (ex_mem_regwrite && !ex_mem_is_load && id_ex_use_b && (ex_mem_rd == id_ex_rs_b))
         fwd_b = 2'b10;
      else if (mem_wb_regwrite && id_ex_use_b && (mem_wb_rd == id_ex_rs_b))
         fwd_b = 2'b01;
   end

   assign load_use = ex_mem_is_load && ex_mem_regwrite &&
                     ((id_ex_use_a && (ex_mem_rd == id_ex_rs_a)) ||
                      (id_ex_use_b && (ex_mem_rd == id_ex_rs_b)));

   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      flush_cnt_d   = flush_cnt_q;
      branch_pend_d = branch_pend_q;
      mem_timeout_d = mem_timeout_q;
      hold_front_c  = 1'b0;
      hold_back_c   = 1'b0;
      bubble_c      = 1'b0;
      flush_c       = 1'b0;
      waiting       = 1'b0;
      exit_flush    = 1'b0;
      wait_inc      = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : WW'(wait_cnt_q + 1'b1);

      case (state_q)
         ST_FLUSH: begin
            // EX holds a bubble here, so hazard checks are not needed.
            flush_c     = 1'b1;
            flush_cnt_d = flush_cnt_q - 2'd1;
            if (flush_cnt_q <= 2'd1)
               state_d = ST_RUN;
         end
         default: begin
            waiting = (state_q == ST_MEM_WAIT) ? !dmem_ready : (ex_mem_is_load && !dmem_ready);
            if (waiting) begin
               hold_front_c  = 1'b1;
               hold_back_c   = 1'b1;
               state_d       = ST_MEM_WAIT;
               branch_pend_d = branch_pend_q | branch_taken;
               if (state_q == ST_MEM_WAIT) begin
                  wait_cnt_d = wait_inc;
                  if (wait_inc == WAIT_MAX)
                     mem_timeout_d = 1'b1;
               end
            end else begin
               // Memory done (or never busy): ordinary run-mode hazard rules apply.
               exit_flush    = (state_q == ST_MEM_WAIT) && branch_pend_q;
               wait_cnt_d    = '0;
               branch_pend_d = 1'b0;
               state_d       = ST_RUN;
               if (load_use) begin
                  hold_front_c = 1'b1;
                  bubble_c     = 1'b1;
               end else if (branch_taken && !exit_flush) begin
                  flush_c     = 1'b1;
                  flush_cnt_d = FLUSH_RUN;
                  if (FLUSH_CYC > 1)
                     state_d = ST_FLUSH;
               end
               if (exit_flush) begin
                  flush_cnt_d = FLUSH_INIT;
                  state_d     = ST_FLUSH;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         flush_cnt_q   <= 2'd0;
         branch_pend_q <= 1'b0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         branch_pend_q <= branch_pend_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign forward_a   = rst_n ? fwd_a : 2'b00;
   assign forward_b   = rst_n ? fwd_b : 2'b00;
   assign hold_front  = rst_n & hold_front_c;
   assign hold_back   = rst_n & hold_back_c;
   assign bubble_ex   = rst_n & bubble_c;
   assign flush_front = rst_n & flush_c;
   assign mem_timeout = rst_n & mem_timeout_q;

endmodule

// File: tb/tb_pipeline_interlock_ctrl.sv
// Randomised + directed scoreboard bench for pipeline_interlock_ctrl against an episode-level model.
module tb_pipeline_interlock_ctrl;

   localparam int RW        = 4;
   localparam int FLUSH_CYC = 2;
   localparam int MAX_WAIT  = 15;

   typedef struct packed {
      logic [3:0] rs_a;
      logic [3:0] rs_b;
      logic       use_a;
      logic       use_b;
      logic       emw;
      logic [3:0] emrd;
      logic       eml;
      logic       mww;
      logic [3:0] mwrd;
      logic       rdy;
      logic       br;
   } stim_t;

   typedef struct packed {
      logic [1:0] fa;
      logic [1:0] fb;
      logic       hf;
      logic       hb;
      logic       bub;
      logic       ff;
      logic       to;
   } resp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [RW-1:0] id_ex_rs_a = '0, id_ex_rs_b = '0;
   logic          id_ex_use_a = 1'b0, id_ex_use_b = 1'b0;
   logic          ex_mem_regwrite = 1'b0, ex_mem_is_load = 1'b0;
   logic [RW-1:0] ex_mem_rd = '0, mem_wb_rd = '0;
   logic          mem_wb_regwrite = 1'b0;
   logic          dmem_ready = 1'b1, branch_taken = 1'b0;
   logic [1:0]    forward_a, forward_b;
   logic          hold_front, hold_back, bubble_ex, flush_front, mem_timeout;

   pipeline_interlock_ctrl #(.RW(RW), .FLUSH_CYC(FLUSH_CYC), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_ex_rs_a(id_ex_rs_a), .id_ex_rs_b(id_ex_rs_b),
      .id_ex_use_a(id_ex_use_a), .id_ex_use_b(id_ex_use_b),
      .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .ex_mem_is_load(ex_mem_is_load),
      .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd),
      .dmem_ready(dmem_ready), .branch_taken(branch_taken),
      .forward_a(forward_a), .forward_b(forward_b),
      .hold_front(hold_front), .hold_back(hold_back), .bubble_ex(bubble_ex),
      .flush_front(flush_front), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   resp_t exp_q[$];
   string tag_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   // Reference model: a memory "episode" is a run of consecutive stalled cycles.
   bit m_frozen;
   int m_wait_len;
   int m_flush_left;
   bit m_branch_seen;
   bit m_timeout;

   function automatic logic [1:0] src_of(input logic [3:0] rs, input logic use_x, input stim_t s);
      if (s.emw && !s.eml && use_x && s.emrd == rs) return 2'b10;
      if (s.mww && use_x && s.mwrd == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic issue(input logic rst_v, input stim_t s, input string tag);
      resp_t e;
      bit    lu;
      bit    stalled;
      bit    pend_exit;
      @(posedge clk);
      #1;
      rst_n           = rst_v;
      id_ex_rs_a      = s.rs_a;
      id_ex_rs_b      = s.rs_b;
      id_ex_use_a     = s.use_a;
      id_ex_use_b     = s.use_b;
      ex_mem_regwrite = s.emw;
      ex_mem_rd       = s.emrd;
      ex_mem_is_load  = s.eml;
      mem_wb_regwrite = s.mww;
      mem_wb_rd       = s.mwrd;
      dmem_ready      = s.rdy;
      branch_taken    = s.br;

      e = '0;
      if (!rst_v) begin
         m_frozen = 0; m_wait_len = 0; m_flush_left = 0; m_branch_seen = 0; m_timeout = 0;
      end else begin
         e.fa = src_of(s.rs_a, s.use_a, s);
         e.fb = src_of(s.rs_b, s.use_b, s);
         e.to = m_timeout;
         lu = s.eml && s.emw && ((s.use_a && s.emrd == s.rs_a) || (s.use_b && s.emrd == s.rs_b));
         stalled = m_frozen ? !s.rdy : (s.eml && !s.rdy);
         if (m_flush_left > 0) begin
            e.ff = 1;
            m_flush_left--;
         end else if (stalled) begin
            e.hf = 1; e.hb = 1;
            m_frozen = 1;
            m_wait_len++;
            if (s.br) m_branch_seen = 1;
            if (m_wait_len > MAX_WAIT) m_timeout = 1;
         end else begin
            pend_exit = m_frozen && m_branch_seen;
            if (lu) begin
               e.hf = 1; e.bub = 1;
            end else if (s.br && !pend_exit) begin
               e.ff = 1;
               m_flush_left = FLUSH_CYC - 1;
            end
            if (pend_exit) m_flush_left = FLUSH_CYC;
            m_frozen = 0; m_wait_len = 0; m_branch_seen = 0;
         end
      end
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   function automatic stim_t idle();
      stim_t s = '0;
      s.rdy = 1'b1;
      return s;
   endfunction

   initial begin : monitor
      resp_t e, got;
      string t;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            got = {forward_a, forward_b, hold_front, hold_back, bubble_ex, flush_front, mem_timeout};
            n_checks++;
            if (got === e) n_pass++;
            else $display("FAIL %s @%0t: got fa=%b fb=%b hf=%b hb=%b bub=%b ff=%b to=%b, want fa=%b fb=%b hf=%b hb=%b bub=%b ff=%b to=%b",
                          t, $time, got.fa, got.fb, got.hf, got.hb, got.bub, got.ff, got.to,
                          e.fa, e.fb, e.hf, e.hb, e.bub, e.ff, e.to);
         end
      end
   end

   initial begin : stimulus
      stim_t s;
      s = idle();
      s.eml = 1; s.emw = 1; s.emrd = 4'd2; s.rs_a = 4'd2; s.use_a = 1; s.rdy = 0;
      repeat (3) issue(1'b0, s, "reset");

      // Randomised phase over a small register window to provoke hazards.
      for (int i = 0; i < 1500; i++) begin
         s.rs_a  = 4'($urandom_range(0, 3));
         s.rs_b  = 4'($urandom_range(0, 3));
         s.use_a = 1'($urandom_range(0, 1));
         s.use_b = 1'($urandom_range(0, 1));
         s.emw   = 1'($urandom_range(0, 3) != 0);
         s.emrd  = 4'($urandom_range(0, 3));
         s.eml   = 1'($urandom_range(0, 2) == 0);
         s.mww   = 1'($urandom_range(0, 1));
         s.mwrd  = 4'($urandom_range(0, 3));
         s.rdy   = 1'($urandom_range(0, 2) != 0);
         s.br    = 1'($urandom_range(0, 5) == 0);
         issue(1'b1, s, "random");
      end

      s = idle();
      issue(1'b0, s, "reset2");
      issue(1'b1, s, "idle");

      // EX/MEM beats MEM/WB on the same register.
      s = idle();
      s.emw = 1; s.emrd = 4'd3; s.rs_a = 4'd3; s.use_a = 1;
      s.mww = 1; s.mwrd = 4'd3; s.rs_b = 4'd7; s.use_b = 1;
      issue(1'b1, s, "fwd_exmem_priority");

      // Load-use bubble, then value forwarded from MEM/WB.
      s = idle();
      s.emw = 1; s.eml = 1; s.emrd = 4'd5; s.rs_b = 4'd5; s.use_b = 1;
      issue(1'b1, s, "load_use_bubble");
      s = idle();
      s.mww = 1; s.mwrd = 4'd5; s.rs_b = 4'd5; s.use_b = 1;
      issue(1'b1, s, "load_use_fwd_wb");

      // Short dmem stall (no timeout), then long stall (timeout, sticky).
      s = idle();
      s.emw = 1; s.eml = 1; s.emrd = 4'd9; s.rdy = 0;
      repeat (4) issue(1'b1, s, "wait4");
      s.rdy = 1;
      issue(1'b1, s, "wait4_done");
      issue(1'b1, idle(), "wait4_after");
      s.rdy = 0;
      repeat (16) issue(1'b1, s, "wait16");
      s.rdy = 1;
      issue(1'b1, s, "wait16_done");
      repeat (3) issue(1'b1, idle(), "timeout_sticky");

      // Branch latched while frozen, flushed on exit.
      s = idle();
      s.emw = 1; s.eml = 1; s.emrd = 4'd1; s.rdy = 0;
      issue(1'b1, s, "br_wait");
      s.br = 1;
      issue(1'b1, s, "br_wait_pulse");
      s.br = 0;
      issue(1'b1, s, "br_wait");
      s.rdy = 1;
      issue(1'b1, s, "br_wait_done");
      repeat (4) issue(1'b1, idle(), "br_flush");

      // Reset in the middle of a wait with a pending branch.
      s = idle();
      s.emw = 1; s.eml = 1; s.emrd = 4'd6; s.rs_a = 4'd6; s.use_a = 1; s.rdy = 0;
      issue(1'b1, s, "rst_wait");
      s.br = 1;
      issue(1'b1, s, "rst_wait_br");
      s.br = 0;
      issue(1'b1, s, "rst_wait");
      repeat (2) issue(1'b0, s, "rst_async_zero");
      repeat (4) issue(1'b1, idle(), "rst_release");

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
